inst_buffer: RTL and testbench

Front-end instruction buffer between fetch and the decoder. It holds fetched instruction packets (pc, instruction word, branch prediction, exception info) in a circular queue. It presents up to DECODER_WIDTH oldest entries per cycle in registered decoder slots, and absorbs fetch/decode rate mismatch. Flush from ctrl empties it; its full indication goes to ctrl as a pause request.

---
 rtl/inst_buffer_pkg.sv | 16 +
 rtl/inst_buffer_if.sv | 25 ++
 rtl/inst_buffer_ib_regfile.sv | 34 +++
 rtl/inst_buffer.sv | 124 ++++++++++++
 tb/tb_inst_buffer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared pipeline types for the fetch/decode front end.
package pipeline_types;

    localparam int unsigned IB_DEPTH = 16;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     inst;
        logic            pre_is_branch;
        logic            pre_is_branch_taken;
        logic [31:0]     pre_branch_addr;
        logic [5:0]      is_exception;
        logic [5:0][6:0] exception_cause;
    } fetch_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side signals of the instruction buffer.
interface inst_buffer_if #(
    parameter int unsigned FETCH_WIDTH   = 2,
    parameter int unsigned DECODER_WIDTH = 2
);
    import pipeline_types::*;

    logic [FETCH_WIDTH-1:0]                 fetch_valid;
    fetch_entry_t [FETCH_WIDTH-1:0]         fetch_entry;
    logic                                   fetch_ready;
    logic                                   pause_buffer;
    fetch_entry_t [DECODER_WIDTH-1:0]       dec_entry;
    logic [DECODER_WIDTH-1:0]               dec_valid;

    modport master (
        output fetch_valid, fetch_entry,
        input  fetch_ready, pause_buffer, dec_entry, dec_valid
    );

    modport slave (
        input  fetch_valid, fetch_entry,
        output fetch_ready, pause_buffer, dec_entry, dec_valid
    );

endinterface

// File: rtl/inst_buffer_ib_regfile.sv
// Instruction buffer storage: FETCH_WIDTH write ports, DECODER_WIDTH async read ports.
module ib_regfile
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH         = IB_DEPTH,
    parameter int unsigned FETCH_WIDTH   = 2,
    parameter int unsigned DECODER_WIDTH = 2
) (
    input  logic                                        clk,
    input  logic [FETCH_WIDTH-1:0]                      we,
    input  logic [FETCH_WIDTH-1:0][$clog2(DEPTH)-1:0]   waddr,
    input  fetch_entry_t [FETCH_WIDTH-1:0]              wdata,
    input  logic [DECODER_WIDTH-1:0][$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t [DECODER_WIDTH-1:0]            rdata
);

    fetch_entry_t mem [DEPTH];

    // Write addresses are always distinct, so port order does not matter.
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
            if (we[j]) begin
                mem[waddr[j]] <= wdata[j];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DECODER_WIDTH; i++) begin
            rdata[i] = mem[raddr[i]];
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: circular queue feeding registered decoder slots.
// Optional fetch-to-decoder bypass on an empty queue: define INST_BUFFER_BYPASS_EN.
module inst_buffer
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH         = IB_DEPTH,
    parameter int unsigned FETCH_WIDTH   = 2,
    parameter int unsigned DECODER_WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         pause,
    input  logic         pause_decoder,
    inst_buffer_if.slave ib
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0]   ptr_t;
    typedef logic [AW-1:0] idx_t;

    ptr_t head, tail, count;
    ptr_t n_fetch, n_byp, n_load;
    logic adv, do_enq, bypass;

    logic [FETCH_WIDTH-1:0]           we;
    idx_t [FETCH_WIDTH-1:0]           waddr;
    idx_t [DECODER_WIDTH-1:0]         raddr;
    fetch_entry_t [DECODER_WIDTH-1:0] rdata, slot_nxt, slot_q;
    logic [DECODER_WIDTH-1:0]         valid_nxt, valid_q;

    function automatic ptr_t min_p(input ptr_t a, input ptr_t b);
        return (a < b) ? a : b;
    endfunction

    assign count           = tail - head;
    assign ib.fetch_ready  = (ptr_t'(DEPTH) - count) >= ptr_t'(FETCH_WIDTH);
    assign ib.pause_buffer = !ib.fetch_ready;
    assign ib.dec_entry    = slot_q;
    assign ib.dec_valid    = valid_q;

    assign adv    = !pause && !pause_decoder;
    assign do_enq = ib.fetch_ready && !flush;

`ifdef INST_BUFFER_BYPASS_EN
    assign bypass = (count == '0) && adv && ib.fetch_valid[0] && do_enq;
`else
    assign bypass = 1'b0;
`endif

    // fetch_valid is contiguous from slot 0, so a popcount gives the packet count.
    always_comb begin
        n_fetch = '0;
        for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
            if (ib.fetch_valid[j]) begin
                n_fetch = n_fetch + ptr_t'(1);
            end
        end
    end

    assign n_byp  = bypass ? min_p(n_fetch, ptr_t'(DECODER_WIDTH)) : '0;
    assign n_load = adv ? min_p(count, ptr_t'(DECODER_WIDTH)) : '0;

    // Bypassed slots skip storage; any leftovers are packed down to tail.
    always_comb begin
        for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
            we[j]    = do_enq && ib.fetch_valid[j] && (ptr_t'(j) >= n_byp);
            waddr[j] = idx_t'(tail + ptr_t'(j) - n_byp);
        end
        for (int unsigned i = 0; i < DECODER_WIDTH; i++) begin
            raddr[i] = idx_t'(head + ptr_t'(i));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DECODER_WIDTH; i++) begin
            slot_nxt[i]  = '0;
            valid_nxt[i] = 1'b0;
            if (ptr_t'(i) < n_load) begin
                slot_nxt[i]  = rdata[i];
                valid_nxt[i] = 1'b1;
            end else if (ptr_t'(i) < n_byp) begin
                slot_nxt[i]  = ib.fetch_entry[i];
                valid_nxt[i] = 1'b1;
            end
        end
    end

    ib_regfile #(
        .DEPTH         (DEPTH),
        .FETCH_WIDTH   (FETCH_WIDTH),
        .DECODER_WIDTH (DECODER_WIDTH)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (ib.fetch_entry),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            slot_q  <= '0;
            valid_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            slot_q  <= '0;
            valid_q <= '0;
        end else begin
            tail <= tail + (do_enq ? (n_fetch - n_byp) : '0);
            if (adv) begin
                head    <= head + n_load;
                slot_q  <= slot_nxt;
                valid_q <= valid_nxt;
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: stimulus queues expected pcs, a negedge monitor retires them.
module tb_inst_buffer;
    import pipeline_types::*;

    logic clk = 1'b0;
    logic rst, flush, pause, pause_decoder;

    inst_buffer_if #(.FETCH_WIDTH(2), .DECODER_WIDTH(2)) ib ();

    inst_buffer #(
        .DEPTH         (16),
        .FETCH_WIDTH   (2),
        .DECODER_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .pause         (pause),
        .pause_decoder (pause_decoder),
        .ib            (ib)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        last_acc;

    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e                    = '0;
        e.pc                 = pc;
        e.inst               = {pc[15:0], 16'h0293};
        e.pre_is_branch      = pc[3];
        e.pre_is_branch_taken = pc[4];
        e.pre_branch_addr    = pc + 32'h40;
        e.is_exception       = pc[7:2];
        e.exception_cause[1] = pc[8:2];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present n packets starting at pc0 for one clock; queue them if the buffer takes them.
    task automatic drive(input int n, input logic [31:0] pc0);
        ib.fetch_valid    = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        ib.fetch_entry[0] = mk(pc0);
        ib.fetch_entry[1] = mk(pc0 + 32'd4);
        last_acc = ib.fetch_ready && !flush && (n > 0);
        if (last_acc) begin
            for (int k = 0; k < n; k++) exp_q.push_back(pc0 + 32'(4 * k));
        end
        cyc();
        ib.fetch_valid = 2'b00;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) cyc();
        chk(name, 64'(exp_q.size()), 64'd0);
        cyc();
        cyc();
    endtask

    // Slots present at a non-flushed advance edge are retired by the decoder.
    always @(negedge clk) begin
        if (!rst && !flush && !pause && !pause_decoder) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ib.dec_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out slot%0d: got pc %h required none", i, ib.dec_entry[i].pc);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        if (ib.dec_entry[i] !== mk(e)) begin
                            errors++;
                            $display("FAIL order slot%0d: got pc %h required pc %h", i, ib.dec_entry[i].pc, e);
                        end
                    end
                end else if (ib.dec_entry[i] !== '0) begin
                    errors++;
                    $display("FAIL bubble_zero slot%0d: got pc %h required 0", i, ib.dec_entry[i].pc);
                end
            end
        end
    end

    initial begin
        int sent;
        int tries;
        int n;

        rst = 1'b1; flush = 1'b0; pause = 1'b0; pause_decoder = 1'b0;
        ib.fetch_valid = '0;
        ib.fetch_entry = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        chk("reset_dec_valid", 64'(ib.dec_valid), 64'h0);
        chk("reset_pc0", 64'(ib.dec_entry[0].pc), 64'h0);
        chk("reset_fetch_ready", 64'(ib.fetch_ready), 64'h1);
        chk("reset_pause_buffer", 64'(ib.pause_buffer), 64'h0);

        // Single pair, decoder always advancing.
        drive(2, 32'h1c00_0000);
`ifndef INST_BUFFER_BYPASS_EN
        cyc();
`endif
        chk("single_dec_valid", 64'(ib.dec_valid), 64'h3);
        chk("single_pc0", 64'(ib.dec_entry[0].pc), 64'h1c00_0000);
        chk("single_pc1", 64'(ib.dec_entry[1].pc), 64'h1c00_0004);

        // Odd count: one packet, then a pair continuing the sequence.
        drive(1, 32'h1c00_0010);
`ifndef INST_BUFFER_BYPASS_EN
        cyc();
`endif
        chk("odd_dec_valid", 64'(ib.dec_valid), 64'h1);
        chk("odd_pc0", 64'(ib.dec_entry[0].pc), 64'h1c00_0010);
        chk("odd_slot1_zero", 64'(ib.dec_entry[1] == '0), 64'h1);
        drive(2, 32'h1c00_0014);
        drain("odd_drain");

        // Fill with the decoder stalled; the ninth pair must be dropped.
        pause_decoder = 1'b1;
        for (int p = 0; p < 8; p++) begin
            chk("fill_ready_before_push", 64'(ib.fetch_ready), 64'h1);
            drive(2, 32'h1c00_0200 + 32'(8 * p));
        end
        chk("fill_ready_full", 64'(ib.fetch_ready), 64'h0);
        chk("fill_pause_buffer", 64'(ib.pause_buffer), 64'h1);
        chk("fill_slots_held", 64'(ib.dec_valid), 64'h0);
        drive(2, 32'h1c00_0f00);
        chk("fill_ready_still_full", 64'(ib.fetch_ready), 64'h0);
        pause_decoder = 1'b0;
        drain("fill_drain");
        chk("fill_ready_after_drain", 64'(ib.fetch_ready), 64'h1);

        // Flush with nine entries queued and a same-cycle enqueue.
        pause_decoder = 1'b1;
        for (int p = 0; p < 4; p++) drive(2, 32'h1c00_0400 + 32'(8 * p));
        drive(1, 32'h1c00_0420);
        flush = 1'b1;
        exp_q.delete();
        drive(2, 32'h1c00_0300);
        flush = 1'b0;
        chk("flush_dec_valid", 64'(ib.dec_valid), 64'h0);
        chk("flush_pc0", 64'(ib.dec_entry[0].pc), 64'h0);
        chk("flush_fetch_ready", 64'(ib.fetch_ready), 64'h1);
        pause_decoder = 1'b0;
        drive(2, 32'h1c00_0100);
`ifndef INST_BUFFER_BYPASS_EN
        cyc();
`endif
        chk("flush_first_pc", 64'(ib.dec_entry[0].pc), 64'h1c00_0100);
        drain("flush_drain");

        // Stream 40 sequential pcs through wrap-around under random stalls.
        sent = 0;
        tries = 0;
        while (sent < 40 && tries < 500) begin
            pause         = ($urandom_range(0, 3) == 0);
            pause_decoder = ($urandom_range(0, 4) == 0);
            n = (sent == 39 || $urandom_range(0, 2) == 0) ? 1 : 2;
            drive(n, 32'h1c00_1000 + 32'(4 * sent));
            if (last_acc) sent += n;
            tries++;
        end
        chk("wrap_sent", 64'(sent), 64'd40);
        pause = 1'b0;
        pause_decoder = 1'b0;
        drain("wrap_drain");

        // Asynchronous reset with loaded slots and seven entries queued.
        drive(2, 32'h1c00_2000);
`ifndef INST_BUFFER_BYPASS_EN
        cyc();
`endif
        pause_decoder = 1'b1;
        for (int p = 0; p < 3; p++) drive(2, 32'h1c00_2100 + 32'(8 * p));
        drive(1, 32'h1c00_2118);
        chk("prereset_dec_valid", 64'(ib.dec_valid), 64'h3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midreset_dec_valid", 64'(ib.dec_valid), 64'h0);
        chk("midreset_pc0", 64'(ib.dec_entry[0].pc), 64'h0);
        chk("midreset_fetch_ready", 64'(ib.fetch_ready), 64'h1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pause_decoder = 1'b0;
        cyc();
        drive(2, 32'h1c00_3000);
        drain("postreset_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
